row_group_skew: RTL and testbench

- Parametrised successor row group for the input router.
- Buffers per-row operand bytes in LANES independent FIFOs, then streams them to the systolic array with a programmable diagonal skew: lane i starts i cycles after lane 0 and also stops i cycles later.
- Adds active-lane count, skew bypass, programmable stream length, per-lane output valid, overflow/underrun flags and a done pulse.

---
 rtl/row_group_skew.sv | 190 +++++++++++++++++++
 tb/tb_row_group_skew.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_group_skew.sv
// row_group_skew: per-row operand FIFOs feeding the systolic array with a
// programmable diagonal skew. Lane i starts and stops i cycles after lane 0
// when skew is enabled, or all active lanes run aligned when it is not.
module row_group_skew #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_reg_clear,
  input  logic                          i_wr_en,
  input  logic [$clog2(LANES)-1:0]      i_wr_lane,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  input  logic                          i_start,
  input  logic [LEN_WIDTH-1:0]          i_len,
  input  logic [$clog2(LANES):0]        i_active_lanes,
  input  logic                          i_skew_en,
  output logic [LANES*DATA_WIDTH-1:0]   o_data,
  output logic [LANES-1:0]              o_valid,
  output logic [LANES-1:0]              o_empty,
  output logic [LANES-1:0]              o_full,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_overflow,
  output logic                          o_underrun
);

  localparam int LW = $clog2(LANES);
  localparam int NW = LW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = LEN_WIDTH + LW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [NW-1:0]        act_q;
  logic                 skew_q;
  logic [TW-1:0]        t;

  logic [NW-1:0]        act_clamp;
  logic [TW-1:0]        span;
  logic [TW-1:0]        last_t;

  logic [LANES-1:0]     sched;
  logic [LANES-1:0]     pop;
  logic [LANES-1:0]     wr_sel;
  logic [LANES-1:0]     wr_acc;
  logic [LANES-1:0]     empty;
  logic [LANES-1:0]     full;

  logic                 overflow_q;
  logic                 underrun_q;

  // Clamp the requested lane count into 1..LANES and find the last stream cycle.
  always_comb begin
    act_clamp = i_active_lanes;
    if (i_active_lanes == '0)
      act_clamp = NW'(1);
    else if (i_active_lanes > NW'(LANES))
      act_clamp = NW'(LANES);
    span   = skew_q ? (TW'(act_q) - TW'(1)) : '0;
    last_t = TW'(len_q) + span - TW'(1);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [TW-1:0]         lane_start;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // A full lane can still take a write when it pops in the same cycle.
    assign lane_start = skew_q ? TW'(g) : '0;
    assign empty[g]   = (count == '0);
    assign full[g]    = (count == CW'(DEPTH));
    assign sched[g]   = (state == ST_STREAM) && (NW'(g) < act_q) &&
                        (t >= lane_start) && (t < TW'(len_q) + lane_start);
    assign pop[g]     = sched[g] && !empty[g];
    assign wr_sel[g]  = i_wr_en && (i_wr_lane == LW'(g));
    assign wr_acc[g]  = wr_sel[g] && (!full[g] || pop[g]);

    // Element storage; contents are don't-care once the pointers are cleared.
    always_ff @(posedge i_clk) begin
      if (wr_acc[g] && !i_reg_clear)
        mem[wr_ptr] <= i_wr_data;
    end

    // Pointer and occupancy tracking for this lane.
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (i_reg_clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc[g])
          wr_ptr <= wr_ptr + AW'(1);
        if (pop[g])
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(wr_acc[g]) - CW'(pop[g]);
      end
    end

    // Registered output: the popped head, or zero when this lane is not popping.
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (i_reg_clear) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= pop[g] ? mem[rd_ptr] : '0;
        valid_q <= pop[g];
      end
    end

    assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign o_valid[g] = valid_q;
  end

  // Stream sequencer: IDLE latches the configuration, STREAM walks t, DONE pulses.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      act_q  <= '0;
      skew_q <= 1'b0;
      t      <= '0;
    end else if (i_reg_clear) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      act_q  <= '0;
      skew_q <= 1'b0;
      t      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            len_q  <= i_len;
            act_q  <= act_clamp;
            skew_q <= i_skew_en;
            t      <= '0;
            state  <= (i_len == '0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          t <= t + TW'(1);
          if (t == last_t)
            state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags, only cleared by reset or clear.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else if (i_reg_clear) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (|(wr_sel & full & ~pop));
      underrun_q <= underrun_q | (|(sched & empty));
    end
  end

  assign o_empty    = empty;
  assign o_full     = full;
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE);
  assign o_overflow = overflow_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_row_group_skew.sv
// tb_row_group_skew: directed test-plan scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model of the stream rules.
module tb_row_group_skew;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LENW  = 8;
  localparam int LW    = 2;
  localparam int NW    = 3;

  logic                  i_clk = 1'b0;
  logic                  i_nrst;
  logic                  i_reg_clear;
  logic                  i_wr_en;
  logic [LW-1:0]         i_wr_lane;
  logic [DW-1:0]         i_wr_data;
  logic                  i_start;
  logic [LENW-1:0]       i_len;
  logic [NW-1:0]         i_active_lanes;
  logic                  i_skew_en;
  logic [LANES*DW-1:0]   o_data;
  logic [LANES-1:0]      o_valid;
  logic [LANES-1:0]      o_empty;
  logic [LANES-1:0]      o_full;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_overflow;
  logic                  o_underrun;

  row_group_skew #(.LANES(LANES), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LENW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
    .i_wr_en(i_wr_en), .i_wr_lane(i_wr_lane), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_len(i_len), .i_active_lanes(i_active_lanes),
    .i_skew_en(i_skew_en), .o_data(o_data), .o_valid(o_valid),
    .o_empty(o_empty), .o_full(o_full), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one queue per lane plus a stream position counter.
  logic [DW-1:0]       mq [LANES][$];
  bit                  m_active;
  int                  m_pos, m_total, m_len, m_act, m_skew;
  bit                  m_ovf, m_und;
  logic [LANES*DW-1:0] e_data;
  logic [LANES-1:0]    e_valid;

  task automatic modelReset();
    for (int i = 0; i < LANES; i++) mq[i].delete();
    m_active = 0; m_pos = 0; m_total = 0; m_len = 0; m_act = 1; m_skew = 0;
    m_ovf = 0; m_und = 0; e_data = '0; e_valid = '0;
  endtask

  task automatic modelEdge();
    logic [LANES*DW-1:0] nd;
    logic [LANES-1:0]    popped;
    int                  a;
    if (i_reg_clear) begin
      modelReset();
      return;
    end
    nd = '0; popped = '0;
    if (m_active && m_pos < m_total) begin
      for (int i = 0; i < m_act; i++) begin
        if (m_pos >= m_skew * i && m_pos < m_len + m_skew * i) begin
          if (mq[i].size() > 0) begin
            nd[i*DW +: DW] = mq[i].pop_front();
            popped[i] = 1'b1;
          end else begin
            m_und = 1;
          end
        end
      end
    end
    if (i_wr_en) begin
      if (mq[i_wr_lane].size() < DEPTH) mq[i_wr_lane].push_back(i_wr_data);
      else m_ovf = 1;
    end
    if (!m_active) begin
      if (i_start) begin
        a = int'(i_active_lanes);
        if (a == 0) a = 1;
        if (a > LANES) a = LANES;
        m_len = int'(i_len); m_act = a; m_skew = i_skew_en ? 1 : 0;
        m_total = (m_len == 0) ? 0 : m_len + m_skew * (a - 1);
        m_pos = 0; m_active = 1;
      end
    end else if (m_pos < m_total) begin
      m_pos++;
    end else begin
      m_active = 0;
    end
    e_data = nd; e_valid = popped;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic checkAll();
    logic [LANES-1:0] ee, ef;
    for (int i = 0; i < LANES; i++) begin
      ee[i] = (mq[i].size() == 0);
      ef[i] = (mq[i].size() == DEPTH);
    end
    checkOutput("data",     64'(o_data),     64'(e_data));
    checkOutput("valid",    64'(o_valid),    64'(e_valid));
    checkOutput("empty",    64'(o_empty),    64'(ee));
    checkOutput("full",     64'(o_full),     64'(ef));
    checkOutput("busy",     64'(o_busy),     64'(m_active));
    checkOutput("done",     64'(o_done),     64'(m_active && m_pos == m_total));
    checkOutput("overflow", 64'(o_overflow), 64'(m_ovf));
    checkOutput("underrun", 64'(o_underrun), 64'(m_und));
  endtask

  // One clock cycle: drive inputs, clock, advance the model, check just after the edge.
  task automatic applyStimulus(input bit wr, input int lane, input int data, input bit st,
                               input int len, input int act, input bit sk, input bit clr);
    i_wr_en = wr; i_wr_lane = LW'(lane); i_wr_data = DW'(data);
    i_start = st; i_len = LENW'(len); i_active_lanes = NW'(act); i_skew_en = sk;
    i_reg_clear = clr;
    @(posedge i_clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write(input int lane, input int data);
    applyStimulus(1, lane, data, 0, 0, 0, 0, 0);
  endtask

  task automatic startStream(input int len, input int act, input bit sk);
    applyStimulus(0, 0, 0, 1, len, act, sk, 0);
  endtask

  task automatic clearAll();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic fillPattern();
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 4; k++) write(i, 16 * i + k);
  endtask

  task automatic asyncReset();
    #2;
    i_nrst = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  initial begin
    i_nrst = 1'b0; i_reg_clear = 0; i_wr_en = 0; i_wr_lane = '0; i_wr_data = '0;
    i_start = 0; i_len = '0; i_active_lanes = '0; i_skew_en = 0;
    modelReset();
    #12;
    checkAll();
    checkOutput("reset_empty", 64'(o_empty), 64'hF);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // Skewed stream across all four lanes.
    fillPattern();
    startStream(4, 4, 1);
    idle(9);
    checkOutput("skew_all_empty", 64'(o_empty), 64'hF);

    // Aligned stream on two lanes only.
    fillPattern();
    startStream(3, 2, 0);
    idle(5);
    checkOutput("aligned_empty", 64'(o_empty), 64'h0);

    // Overflow, then streaming through a full lane with pointer wrap.
    clearAll();
    for (int k = 0; k <= DEPTH; k++) write(2, 32 + k);
    checkOutput("ovf_full", 64'(o_full), 64'h4);
    checkOutput("ovf_flag", 64'(o_overflow), 64'h1);
    startStream(DEPTH, 3, 0);
    for (int k = 0; k < DEPTH; k++) write(2, 128 + k);
    idle(3);

    // Underrun on lane 1.
    clearAll();
    for (int k = 0; k < 4; k++) write(0, 64 + k);
    write(1, 90); write(1, 91);
    startStream(4, 2, 1);
    idle(7);
    checkOutput("underrun_sticky", 64'(o_underrun), 64'h1);

    // Zero-length start, then a second start ignored mid-stream.
    clearAll();
    startStream(0, 3, 1);
    idle(2);
    fillPattern();
    startStream(5, 1, 0);
    idle(2);
    startStream(9, 4, 1);
    idle(6);

    // Synchronous clear and asynchronous reset mid-stream.
    fillPattern();
    startStream(4, 4, 1);
    idle(3);
    clearAll();
    checkOutput("clear_busy", 64'(o_busy), 64'h0);
    fillPattern();
    startStream(4, 4, 1);
    idle(2);
    asyncReset();
    checkOutput("nrst_empty", 64'(o_empty), 64'hF);

    // Randomized traffic with random configurations and occasional clears.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, LANES - 1),
                    $urandom_range(0, 255), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 20), $urandom_range(0, 7),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0);
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
